// File: rtl/simple_dma_controller_if.sv
// rtl/simple_dma_controller_if.sv - device request/handshake and DMA memory port bundle
interface simple_dma_controller_if;
   logic        dev_rqst;
   logic        dev_rd_wr;
   logic [15:0] dev_start_addr;
   logic [15:0] dev_num_words;
   logic        dev_ack;
   logic [15:0] dev_wdata;
   logic [15:0] dev_rdata;
   logic        dma_ack;
   logic        dma_end_flag;
   logic        dma_error_flag;
   logic [14:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_en;
   logic [1:0]  mem_we;
   logic        mem_priority;
   logic [15:0] mem_dout;
   logic        mem_ready;
   logic        mem_resp;

   modport slave (
      input  dev_rqst, dev_rd_wr, dev_start_addr, dev_num_words, dev_ack, dev_wdata,
      input  mem_dout, mem_ready, mem_resp,
      output dev_rdata, dma_ack, dma_end_flag, dma_error_flag,
      output mem_addr, mem_din, mem_en, mem_we, mem_priority
   );

   modport master (
      output dev_rqst, dev_rd_wr, dev_start_addr, dev_num_words, dev_ack, dev_wdata,
      output mem_dout, mem_ready, mem_resp,
      input  dev_rdata, dma_ack, dma_end_flag, dma_error_flag,
      input  mem_addr, mem_din, mem_en, mem_we, mem_priority
   );
endinterface

// File: rtl/simple_dma_controller.sv
// rtl/simple_dma_controller.sv - word-at-a-time block DMA between a device handshake and the DMA memory port
module simple_dma_controller #(
   parameter logic PRIORITY = 1'b0
) (
   input logic                    clk,
   input logic                    reset,
   simple_dma_controller_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_WAIT_DEV, S_XFER, S_ACK, S_SETTLE, S_DONE, S_ERR, S_DRAIN
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_addr;
   logic [15:0] r_cnt;
   logic [15:0] r_rdata;
   logic        r_dir;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (bus.dev_rqst) w_next = S_LOAD;
         S_LOAD:     w_next = (bus.dev_num_words == 16'd0) ? S_DONE : S_WAIT_DEV;
         S_WAIT_DEV: begin
            if (!bus.dev_rqst)    w_next = S_IDLE;
            else if (bus.dev_ack) w_next = S_XFER;
         end
         // a request drop cannot cancel an access the memory port has already seen
         S_XFER:     if (bus.mem_ready) w_next = bus.mem_resp ? S_ERR : S_ACK;
         S_ACK: begin
            if (r_cnt == 16'd1)    w_next = S_DONE;
            else if (!bus.dev_rqst) w_next = S_IDLE;
            else                   w_next = S_SETTLE;
         end
         S_SETTLE:   w_next = S_WAIT_DEV;
         S_DONE:     w_next = S_DRAIN;
         S_ERR:      w_next = S_DRAIN;
         S_DRAIN:    if (!bus.dev_rqst) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= 16'd0;
         r_cnt   <= 16'd0;
         r_dir   <= 1'b0;
         r_rdata <= 16'd0;
      end else begin
         if (r_state == S_LOAD) begin
            r_addr <= {bus.dev_start_addr[15:1], 1'b0};
            r_cnt  <= bus.dev_num_words;
            r_dir  <= bus.dev_rd_wr;
         end
         if (r_state == S_ACK) begin
            r_addr <= r_addr + 16'd2;
            r_cnt  <= r_cnt - 16'd1;
            if (r_dir) r_rdata <= bus.mem_dout;
         end
      end
   end

   always_comb begin
      bus.mem_en         = 1'b0;
      bus.mem_addr       = 15'd0;
      bus.mem_we         = 2'b00;
      bus.mem_din        = 16'd0;
      bus.dma_ack        = 1'b0;
      bus.dma_end_flag   = 1'b0;
      bus.dma_error_flag = 1'b0;
      bus.dev_rdata      = r_rdata;
      case (r_state)
         S_XFER: begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = r_addr[15:1];
            bus.mem_we   = r_dir ? 2'b00 : 2'b11;
            bus.mem_din  = r_dir ? 16'd0 : bus.dev_wdata;
         end
         // read data arrives the cycle after mem_ready, so it is forwarded straight through
         S_ACK: begin
            bus.dma_ack = 1'b1;
            if (r_dir) bus.dev_rdata = bus.mem_dout;
         end
         S_DONE:  bus.dma_end_flag   = 1'b1;
         S_ERR:   bus.dma_error_flag = 1'b1;
         default: ;
      endcase
   end

   assign bus.mem_priority = PRIORITY;

endmodule

// File: tb/tb_simple_dma_controller.sv
// tb/tb_simple_dma_controller.sv - randomized block transfers against a memory/device model with a transfer-level reference
module tb_simple_dma_controller;
   localparam logic PRIO = 1'b0;

   logic clk = 1'b0;
   logic reset = 1'b1;

   simple_dma_controller_if dma_bus ();

   simple_dma_controller #(.PRIORITY(PRIO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dma_bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic [15:0] mem [0:32767];

   int cfg_waits = 0, cfg_err_at = 0, wait_cnt = 0, acc_num = 0;
   bit rd_pending = 1'b0;
   logic [15:0] rd_word;
   logic [14:0] log_addr[$];
   logic [1:0]  log_we[$];
   logic [15:0] log_din[$];

   bit dev_active = 1'b0, pulse_mode = 1'b0;
   int widx = 0, gap = 0;
   logic [15:0] wq[$];
   logic [15:0] preset_wq[$];

   int ack_cnt, end_cnt, err_cnt, overlap, en_noack, en_cycles, end_cyc;
   bit prev_en = 1'b0;
   int en_start[$];
   logic [15:0] ack_data[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // memory port: fixed wait count per access, optional error on the Nth access
   always begin
      @(posedge clk); #1;
      dma_bus.mem_ready = 1'b0;
      dma_bus.mem_resp  = 1'b0;
      dma_bus.mem_dout  = rd_pending ? rd_word : 16'($urandom);
      rd_pending = 1'b0;
      if (reset) wait_cnt = 0;
      else if (dma_bus.mem_en) begin
         if (wait_cnt < cfg_waits) wait_cnt++;
         else begin
            wait_cnt = 0;
            acc_num++;
            dma_bus.mem_ready = 1'b1;
            dma_bus.mem_resp  = (acc_num == cfg_err_at);
            log_addr.push_back(dma_bus.mem_addr);
            log_we.push_back(dma_bus.mem_we);
            log_din.push_back(dma_bus.mem_din);
            if (dma_bus.mem_we == 2'b11) mem[dma_bus.mem_addr] = dma_bus.mem_din;
            else begin
               rd_word = mem[dma_bus.mem_addr];
               rd_pending = 1'b1;
            end
         end
      end
   end

   // device: next write word after each dma_ack; in pulse mode dev_ack drops for a random gap
   always begin
      @(posedge clk); #2;
      if (dev_active && dma_bus.dma_ack) begin
         widx++;
         if (widx < wq.size()) dma_bus.dev_wdata = wq[widx];
         if (pulse_mode) begin
            dma_bus.dev_ack = 1'b0;
            gap = $urandom_range(1, 3);
         end
      end else if (dev_active && pulse_mode && !dma_bus.dev_ack) begin
         if (gap == 0) dma_bus.dev_ack = 1'b1;
         else gap--;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (dma_bus.dma_ack) begin
         ack_cnt++;
         ack_data.push_back(dma_bus.dev_rdata);
      end
      if (dma_bus.dma_end_flag) begin
         end_cnt++;
         end_cyc = cyc;
      end
      if (dma_bus.dma_error_flag) err_cnt++;
      if (32'(dma_bus.dma_ack) + 32'(dma_bus.dma_end_flag) + 32'(dma_bus.dma_error_flag) > 1) overlap++;
      if (dma_bus.mem_en && !dma_bus.dev_ack) en_noack++;
      if (dma_bus.mem_en) en_cycles++;
      if (dma_bus.mem_en && !prev_en) en_start.push_back(cyc);
      prev_en = dma_bus.mem_en;
   end

   task automatic clear_all();
      ack_cnt = 0; end_cnt = 0; err_cnt = 0; overlap = 0; en_noack = 0; en_cycles = 0; end_cyc = 0;
      en_start.delete(); ack_data.delete();
      log_addr.delete(); log_we.delete(); log_din.delete();
      acc_num = 0; wait_cnt = 0;
   endtask

   task automatic start_block(input logic [15:0] start, input int n, input bit rd, input int waits,
                              input int err_at, input bit pulse, output int c0);
      clear_all();
      cfg_waits = waits;
      cfg_err_at = err_at;
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(preset_wq.size() > i ? preset_wq[i] : 16'($urandom));
      preset_wq.delete();
      @(negedge clk); #1;
      dma_bus.dev_start_addr = start;
      dma_bus.dev_num_words  = 16'(n);
      dma_bus.dev_rd_wr      = rd;
      dma_bus.dev_ack        = 1'b1;
      dma_bus.dev_wdata      = (n > 0) ? wq[0] : 16'h0;
      widx = 0;
      pulse_mode = pulse;
      dev_active = 1'b1;
      c0 = cyc;
      dma_bus.dev_rqst = 1'b1;
   endtask

   task automatic run_block(input string tag, input logic [15:0] start, input int n, input bit rd,
                            input int waits, input int err_at, input bit pulse);
      int c0, exp_acc, exp_ack, en_hold, ack_hold;
      logic [14:0] base, a;
      base = start[15:1];
      exp_acc = (err_at != 0) ? err_at : n;
      exp_ack = (err_at != 0) ? err_at - 1 : n;
      start_block(start, n, rd, waits, err_at, pulse, c0);
      repeat (3) @(negedge clk);
      #1;
      dma_bus.dev_start_addr = 16'($urandom);
      dma_bus.dev_num_words  = 16'(n + 7);
      dma_bus.dev_rd_wr      = ~rd;
      for (int k = 0; k < n * 16 + 40 && end_cnt + err_cnt == 0; k++) @(negedge clk);
      check({tag, " completion"}, 32'(end_cnt + err_cnt > 0), 32'd1);
      en_hold = en_cycles;
      ack_hold = ack_cnt;
      repeat (4) @(negedge clk);
      check({tag, " drain quiet"}, 32'(en_cycles - en_hold + ack_cnt - ack_hold), 32'd0);
      #1;
      dma_bus.dev_rqst = 1'b0;
      dev_active = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, " ack count"}, 32'(ack_cnt), 32'(exp_ack));
      check({tag, " end count"}, 32'(end_cnt), (err_at != 0) ? 32'd0 : 32'd1);
      check({tag, " err count"}, 32'(err_cnt), (err_at != 0) ? 32'd1 : 32'd0);
      check({tag, " flag overlap"}, 32'(overlap), 32'd0);
      check({tag, " mem_en without dev_ack"}, 32'(en_noack), 32'd0);
      check({tag, " access count"}, 32'(log_addr.size()), 32'(exp_acc));
      check({tag, " mem_en cycles"}, 32'(en_cycles), 32'(exp_acc * (waits + 1)));
      for (int i = 0; i < exp_acc && i < log_addr.size(); i++) begin
         a = base + 15'(i);
         check($sformatf("%s addr[%0d]", tag, i), 32'(log_addr[i]), 32'(a));
         check($sformatf("%s we[%0d]", tag, i), 32'(log_we[i]), rd ? 32'd0 : 32'd3);
         check($sformatf("%s din[%0d]", tag, i), 32'(log_din[i]), rd ? 32'd0 : 32'(wq[i]));
      end
      if (rd)
         for (int i = 0; i < exp_ack && i < ack_data.size(); i++) begin
            a = base + 15'(i);
            check($sformatf("%s rdata[%0d]", tag, i), 32'(ack_data[i]), 32'(mem[a]));
         end
      if (n == 0) check({tag, " zero-word end latency"}, 32'(end_cyc - c0), 32'd2);
      else check({tag, " first mem_en latency"}, en_start.size() > 0 ? 32'(en_start[0] - c0) : 32'hFFFF, 32'd3);
      if (n > 1 && !pulse && (err_at == 0 || err_at > 1))
         check({tag, " word period"}, en_start.size() > 1 ? 32'(en_start[1] - en_start[0]) : 32'hFFFF,
               32'(4 + waits));
   endtask

   initial begin
      int c0, n, err_at;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      dma_bus.dev_rqst = 1'b0;
      dma_bus.dev_rd_wr = 1'b0;
      dma_bus.dev_start_addr = 16'h0;
      dma_bus.dev_num_words = 16'h0;
      dma_bus.dev_ack = 1'b0;
      dma_bus.dev_wdata = 16'h0;
      dma_bus.mem_dout = 16'h0;
      dma_bus.mem_ready = 1'b0;
      dma_bus.mem_resp = 1'b0;
      repeat (3) @(negedge clk);
      check("reset mem_en", 32'(dma_bus.mem_en), 32'd0);
      check("reset mem_we", 32'(dma_bus.mem_we), 32'd0);
      check("reset mem_addr", 32'(dma_bus.mem_addr), 32'd0);
      check("reset mem_din", 32'(dma_bus.mem_din), 32'd0);
      check("reset dev_rdata", 32'(dma_bus.dev_rdata), 32'd0);
      check("reset flags", {29'd0, dma_bus.dma_ack, dma_bus.dma_end_flag, dma_bus.dma_error_flag}, 32'd0);
      check("mem_priority", 32'(dma_bus.mem_priority), 32'(PRIO));
      #1 reset = 1'b0;

      mem[15'h100] = 16'h1111; mem[15'h101] = 16'h2222; mem[15'h102] = 16'h3333;
      run_block("read3", 16'h0200, 3, 1'b1, 0, 0, 1'b0);
      check("read3 word0 literal", ack_data.size() > 0 ? 32'(ack_data[0]) : 32'hFFFF_FFFF, 32'h1111);
      preset_wq.push_back(16'hBEEF);
      preset_wq.push_back(16'hCAFE);
      run_block("write2", 16'h0300, 2, 1'b0, 0, 0, 1'b1);
      check("write2 mem 0x181", 32'(mem[15'h181]), 32'hCAFE);
      run_block("zero", 16'h0400, 0, 1'b1, 0, 0, 1'b0);
      run_block("error", 16'h0500, 4, 1'b1, 0, 2, 1'b0);
      run_block("wrap", 16'hFFFE, 2, 1'b1, 2, 0, 1'b0);

      for (int t = 0; t < 10; t++) begin
         n = $urandom_range(0, 6);
         err_at = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
         run_block($sformatf("rand%0d", t), 16'($urandom), n, 1'($urandom), $urandom_range(0, 2),
                   err_at, 1'($urandom));
      end

      start_block(16'h0600, 5, 1'b1, 0, 0, 1'b0, c0);
      for (int k = 0; k < 20 && !dma_bus.mem_en; k++) @(negedge clk);
      #1 dma_bus.dev_rqst = 1'b0;
      dev_active = 1'b0;
      repeat (6) @(negedge clk);
      check("abort ack count", 32'(ack_cnt), 32'd1);
      check("abort flags", 32'(end_cnt + err_cnt), 32'd0);
      check("abort access count", 32'(log_addr.size()), 32'd1);
      check("abort mem_en idle", 32'(dma_bus.mem_en), 32'd0);

      start_block(16'h0700, 5, 1'b1, 3, 0, 1'b0, c0);
      for (int k = 0; k < 20 && !dma_bus.mem_en; k++) @(negedge clk);
      check("pre-reset mem_en", 32'(dma_bus.mem_en), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async reset mem_en", 32'(dma_bus.mem_en), 32'd0);
      check("async reset mem_addr", 32'(dma_bus.mem_addr), 32'd0);
      check("async reset dev_rdata", 32'(dma_bus.dev_rdata), 32'd0);
      dma_bus.dev_rqst = 1'b0;
      dev_active = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      check("post-reset flags", 32'(ack_cnt + end_cnt + err_cnt), 32'd0);
      check("post-reset mem_en", 32'(dma_bus.mem_en), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
